// File: rtl/pet2001_key_scheduler.sv
// pet2001_key_scheduler: buffers UART bytes in a small FIFO and releases
// them to the keystroke converter with a minimum spacing between strobes.
// The spacing is longer after a carriage return.
module pet2001_key_scheduler #(
  parameter int unsigned FIFO_AW        = 6,
  parameter int unsigned PACE_CYCLES    = 2500000,
  parameter int unsigned CR_PACE_CYCLES = 10000000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         uart_data,
  input  logic               uart_strobe,
  input  logic               pause,
  input  logic               clr_overflow,
  output logic [7:0]         key_data,
  output logic               key_strobe,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               overflow,
  output logic               busy
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;

  typedef enum logic {
    IDLE,
    WAIT
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]         head;
  logic               full, empty, do_push, do_pop;

  // Full is judged on the pre-edge count, so a same-edge pop never frees
  // space for the incoming byte.
  assign full    = (fifo_count == (FIFO_AW + 1)'(DEPTH));
  assign empty   = (fifo_count == '0);
  assign do_push = uart_strobe && !full;
  assign head    = mem[rd_ptr];
  assign busy    = (state != IDLE) || !empty;

  // Next-state and pacing counter; the counter is preloaded with
  // interval-2 so that the issue edge plus the final IDLE edge make up
  // the full interval.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    do_pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!pause && !empty) begin
          do_pop     = 1'b1;
          state_next = WAIT;
          cnt_next   = (head == 8'h0D) ? CNT_W'(CR_PACE_CYCLES - 2)
                                       : CNT_W'(PACE_CYCLES - 2);
        end
      end
      WAIT: begin
        if (!pause) begin
          if (cnt == '0) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_data   <= '0;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= do_pop;
      if (do_pop) begin
        key_data <= head;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   fifo_count <= fifo_count + (FIFO_AW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (FIFO_AW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (uart_strobe && full) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= uart_data;
    end
  end

endmodule

// File: tb/tb_pet2001_key_scheduler.sv
// Self-checking bench for pet2001_key_scheduler: a queue-based reference
// model predicts issued keys into a scoreboard; a monitor checks them.
module tb_pet2001_key_scheduler;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PACE  = 10;
  localparam int unsigned CRP   = 40;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   uart_data = '0;
  logic         uart_strobe = 1'b0;
  logic         pause = 1'b0;
  logic         clr_overflow = 1'b0;
  logic [7:0]   key_data;
  logic         key_strobe;
  logic [AW:0]  fifo_count;
  logic         overflow;
  logic         busy;

  pet2001_key_scheduler #(
    .FIFO_AW(AW),
    .PACE_CYCLES(PACE),
    .CR_PACE_CYCLES(CRP),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .reset(rst),
    .uart_data(uart_data),
    .uart_strobe(uart_strobe),
    .pause(pause),
    .clr_overflow(clr_overflow),
    .key_data(key_data),
    .key_strobe(key_strobe),
    .fifo_count(fifo_count),
    .overflow(overflow),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mq[$];
  int unsigned wait_left = 0;
  logic        m_ovf = 1'b0;
  logic [7:0]  m_key = '0;
  int unsigned cyc = 0;
  logic        drop;
  logic [7:0]  b;
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a byte queue, a sticky overflow flag and a count of
  // pacing cycles still to run before the next key may be issued.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      sb.delete();
      wait_left = 0;
      m_ovf = 1'b0;
      m_key = '0;
    end else begin
      cyc++;
      drop = uart_strobe && (mq.size() == DEPTH);
      if (wait_left > 0) begin
        if (!pause) wait_left--;
      end else if (!pause && mq.size() > 0) begin
        b = mq.pop_front();
        m_key = b;
        wait_left = ((b == 8'h0D) ? CRP : PACE) - 1;
        sb.push_back('{data: b, cyc: cyc});
      end
      if (uart_strobe && !drop) mq.push_back(uart_data);
      if (drop) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
    end
  end

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      chk("fifo_count", int'(fifo_count), mq.size());
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("busy", int'(busy), int'(wait_left > 0 || mq.size() > 0));
      chk("key_data_hold", int'(key_data), int'(m_key));
      if (key_strobe) begin
        if (sb.size() == 0) begin
          chk("unexpected_strobe", int'(key_strobe), 0);
        end else begin
          mon_e = sb.pop_front();
          chk("strobe_data", int'(key_data), int'(mon_e.data));
          chk("strobe_cycle", int'(cyc), int'(mon_e.cyc));
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        chk("missing_strobe", int'(key_strobe), 1);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic s, input logic [7:0] d, input logic p, input logic c);
    uart_strobe  = s;
    uart_data    = d;
    pause        = p;
    clr_overflow = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic p);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, p, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(2, 1'b0);

    // Single byte, then a paced burst, then CR spacing.
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    idle(15, 1'b0);
    drive(1'b1, 8'h41, 1'b0, 1'b0);
    drive(1'b1, 8'h42, 1'b0, 1'b0);
    drive(1'b1, 8'h43, 1'b0, 1'b0);
    idle(35, 1'b0);
    drive(1'b1, 8'h0D, 1'b0, 1'b0);
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    idle(60, 1'b0);

    // Overflow: six bytes into a four-deep FIFO, then clear.
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    idle(3, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    idle(60, 1'b0);

    // Fill while paused in IDLE, then drop and clear on the same edge.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
    drive(1'b1, 8'h66, 1'b1, 1'b1);
    idle(7, 1'b1);
    idle(60, 1'b0);

    // Pause during WAIT stretches the interval.
    drive(1'b1, 8'h70, 1'b0, 1'b0);
    drive(1'b1, 8'h71, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(7, 1'b1);
    idle(30, 1'b0);

    // Asynchronous reset mid-WAIT with bytes queued.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    idle(3, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_key_data", int'(key_data), 0);
    chk("async_rst_key_strobe", int'(key_strobe), 0);
    chk("async_rst_fifo_count", int'(fifo_count), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_overflow", int'(overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(30, 1'b0);
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    idle(15, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) == 0,
            ($urandom_range(0, 7) == 0) ? 8'h0D : 8'($urandom),
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 15) == 0);
    end

    for (int i = 0; i < 2000 && (mq.size() > 0 || wait_left > 0 || sb.size() > 0); i++)
      idle(1, 1'b0);
    idle(2, 1'b0);
    chk("scoreboard_drained", sb.size(), 0);
    chk("model_drained", mq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pet2001_key_scheduler.md
Name: pet2001_key_scheduler

Overview:
Buffers characters from the UART receiver and releases them to the PET keystroke converter (pet2001uart_keys) at a controlled rate. Pasted text and fast host input would otherwise overrun the PET keyboard scan. The block sits between uart.read_data/read_strobe and pet2001uart_keys.uart_data/uart_strobe in the board top level. It holds a small FIFO and a pacing state machine, and carries an extra delay after carriage return so BASIC line entry can finish.

Parameters:
FIFO_AW, 6, FIFO address width; depth = 2**FIFO_AW entries (64).
PACE_CYCLES, 2500000, minimum clk cycles between successive key_strobe pulses (50 ms at 50 MHz); must be >= 2.
CR_PACE_CYCLES, 10000000, spacing applied after issuing byte 8'h0D (200 ms); must be >= 2.
CNT_W, 24, pacing counter width; must hold max(PACE_CYCLES, CR_PACE_CYCLES)-1.

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-high reset
uart_data  in  8  received byte; valid only when uart_strobe=1
uart_strobe  in  1  one-cycle pulse, byte available
pause  in  1  level; when 1, no new key is issued and the pacing counter holds (tied to PET suspend)
clr_overflow  in  1  one-cycle pulse, clears overflow
key_data  out  8  byte presented to the keystroke converter
key_strobe  out  1  one-cycle pulse, key_data valid
fifo_count  out  FIFO_AW+1  current FIFO occupancy, 0..2**FIFO_AW
overflow  out  1  sticky; a byte was dropped because the FIFO was full
busy  out  1  1 when state != IDLE or fifo_count != 0

Behaviour:
- Reset (async, active-high): FIFO pointers=0, fifo_count=0, key_data=8'h00, key_strobe=0, overflow=0, busy=0, state=IDLE, counter=0.
- FIFO write: at a clk edge with uart_strobe=1 and not full, the byte is stored and the count increments.
- Full write: if uart_strobe=1 while full, the byte is dropped, contents are unchanged, and overflow<=1.
- Pop plus write in the same cycle: a push and a pop at the same edge leave the count unchanged.
- When the FIFO is full, a same-edge pop does not free space for that write; the write is dropped and overflow is set.
- overflow: clr_overflow=1 clears it. If a drop and clr_overflow occur on the same edge, the drop wins and overflow=1.
- Pointers: wrap modulo 2**FIFO_AW. full = (count == 2**FIFO_AW); empty = (count == 0).
- State machine, IDLE -> WAIT:
  - Taken at an edge where state=IDLE, pause=0 and the FIFO is non-empty.
  - Actions at that edge: pop the head; key_data<=head; key_strobe<=1.
  - counter<=CR_PACE_CYCLES-2 if head==8'h0D, else PACE_CYCLES-2.
- State machine, WAIT:
  - key_strobe<=0.
  - If pause=1, the counter holds.
  - Else if counter==0, go to IDLE; otherwise the counter decrements.
- key_strobe is high for exactly one cycle per popped byte. key_data holds its value until the next issue.
- Latency: with uart_strobe sampled at edge E0 into an empty FIFO, state IDLE and pause=0, the pop occurs at E1 and key_strobe is high from E1 to E2.
- Spacing: consecutive key_strobe rising edges are exactly PACE_CYCLES edges apart (CR_PACE_CYCLES after 8'h0D), provided the FIFO is non-empty and pause=0 throughout.
- Pause:
  - Asserted in IDLE: blocks issue.
  - Asserted in WAIT: freezes the counter, and the interval stretches by the number of paused cycles.
  - A strobe already registered still completes.
  - FIFO writes continue while paused.
- fifo_count and busy are registered or derived from registered state only; no combinational path from uart_strobe.
- Byte order is strictly FIFO. There is no filtering; every byte, including 8'h00, is forwarded.

Test Plan:
- Reset with PACE_CYCLES=10, CR_PACE_CYCLES=40, FIFO_AW=2. Send 8'h41 at E0 -> key_strobe=1 with key_data=8'h41 in the cycle after E1; fifo_count returns to 0; busy=0 after 10 more edges.
- Burst 8'h41,8'h42,8'h43 on consecutive cycles -> three strobes in order, rising edges exactly 10 cycles apart.
- Send 8'h0D,8'h44 -> strobe for 8'h0D, then strobe for 8'h44 exactly 40 cycles later.
- Burst 6 bytes into the depth-4 FIFO while the first is pacing -> the first 5 bytes are delivered (1 issued plus 4 buffered), the 6th is dropped, and overflow=1. clr_overflow -> overflow=0. A simultaneous drop and clear -> overflow stays 1.
- Assert pause for 7 cycles during WAIT -> the next strobe arrives 17 cycles after the previous one. Pause while IDLE with 2 bytes queued -> no strobe until release; the first strobe comes 1 cycle after deassertion.
- Assert reset asynchronously mid-WAIT with 3 bytes queued -> all outputs are 0 immediately. After release, no strobe occurs until a new byte is written.
